alu_wb_stage: RTL
=================

Name: alu_wb_stage

Overview:
Execute-to-writeback pipeline stage directly downstream of the 16-bit ALU. It captures the ALU result and flags through a two-entry skid buffer with a valid/ready handshake, and presents register-file write requests. It also holds the architectural NZCV status register and evaluates 4-bit branch condition codes for the branch unit.

Parameters:
DATA_W, 16, datapath width; result and write-back data width
REG_ADDR_W, 3, destination register address width (8 registers, r0 hardwired zero)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  ALU stage has an op to hand over
in_ready  output  1  stage can accept this cycle
in_result  input  DATA_W  ALU result R[15:0]
in_c  input  1  ALU carry flag
in_v  input  1  ALU overflow flag
in_fun  input  3  ALU function code of the op (000 ADD, 001 SUB, others logic/shift)
in_rd  input  REG_ADDR_W  destination register
in_wr_en  input  1  op writes a register
in_set_flags  input  1  op updates NZCV
wb_valid  output  1  write-back entry present
wb_ready  input  1  register file consumes entry
wb_we  output  1  register write enable, qualified
wb_rd  output  REG_ADDR_W  write address
wb_data  output  DATA_W  write data
flag_n, flag_z, flag_c, flag_v  output  1 each  architectural status flags
cond  input  4  condition code from branch unit
cond_true  output  1  condition satisfied

Behaviour:
- Reset: state EMPTY, both entries invalid, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, NZCV=0000. in_ready=0 while rst high; inputs ignored in reset cycles. rst mid-transfer drops all buffered entries with no write-back.
- Accept = in_valid & in_ready. Pop = wb_valid & wb_ready.
- in_ready = (state != TWO) & !rst; decoded from the state register only, with no combinational path from wb_ready.
- States: EMPTY, ONE (main valid), TWO (main+skid valid). Output is always driven from main.
  - EMPTY: accept -> ONE (main<-in).
  - ONE: accept & !pop -> TWO (skid<-in). pop & !accept -> EMPTY. Both -> ONE (main<-in). Neither -> hold.
  - TWO: pop -> ONE (main<-skid). Otherwise hold.
- Latency: an op accepted at edge k shows wb_valid=1 from cycle k+1. Throughput is 1 op/cycle when wb_ready stays high. Order is strictly preserved. Entries never drop or duplicate.
- wb_we = wb_valid & main.wr_en & (main.rd != 0). Writes to r0 are suppressed, but the entry is still popped.
- Flags update at the accept edge when in_set_flags=1, independent of write-back stalls:
  - N <- in_result[15].
  - Z <- (in_result == 0). Computed over 16 bits only; ALU bit 16 is ignored.
  - C, V <- in_c, in_v only when in_fun is 000 or 001. Otherwise C and V keep their previous values.
  - in_set_flags=0: NZCV unchanged.
- cond_true is combinational from flag registers:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Stalled outputs: while wb_valid=1 & wb_ready=0, wb_rd, wb_data and wb_we hold stable.

Optional Feature:
ALU_WB_FLAG_BYPASS_EN
- Defined: cond_true is evaluated on the NZCV value being written this cycle when accept & in_set_flags. The same per-field C/V retention rules apply. A branch can therefore resolve in the same cycle its flag-setting op hands over. This adds a combinational path in_* -> cond_true.
- Undefined: cond_true uses registered flags only. The branch unit must wait one cycle after a flag-setting accept.

Test Plan:
- Reset, then ADD in_result=0x0005 rd=3 wr_en set_flags c=0 v=0 with wb_ready=1 -> next cycle wb_valid=1 wb_we=1 wb_rd=3 wb_data=0x0005; NZCV=0000; cond=1 (NE) gives cond_true=1.
- SUB result 0x0000 c=1 v=0 set_flags, then AND result 0x8000 set_flags -> after SUB NZCV=0110; after AND NZCV=1010 (C retained); cond=B (LT) gives cond_true=1.
- wb_ready=0, three back-to-back in_valid ops A,B,C -> A and B accepted, in_ready=0 on the third cycle, C held. Then wb_ready=1 -> write-backs A,B,C in order, no loss or duplicate.
- Op with rd=0 wr_en=1 data 0xFFFF -> wb_valid=1, wb_we=0, entry pops.
- rst asserted while in TWO state -> next cycle wb_valid=0, in_ready=0 during rst, NZCV=0000, then in_ready=1.
- Sweep cond 0..F for NZCV in {0000,0100,1001,0011} -> cond_true matches the table. With ALU_WB_FLAG_BYPASS_EN, cond=0 in the same cycle as a set_flags accept of result 0 -> cond_true=1.

Source files
------------

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute-to-writeback pipeline stage that sits directly after
// the 16-bit ALU.
//
// It captures each ALU result in a two-entry skid buffer guarded by a
// valid/ready handshake, and presents register-file write requests from the
// main (oldest) entry. It also holds the architectural NZCV status register
// and evaluates 4-bit branch condition codes for the branch unit.
//
// Configuration macro:
//   ALU_WB_FLAG_BYPASS_EN - when defined, cond_true sees the NZCV value being
//                           written this cycle on a flag-setting accept.
//                           This adds a combinational in_* -> cond_true path.
//                           When undefined, cond_true uses the registered
//                           flags only.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  handshake with the ALU stage (in_ready is registered-state only)
//   in_result       ALU result
//   in_c/in_v       ALU carry/overflow
//   in_fun          ALU function code (000 ADD, 001 SUB)
//   in_rd           destination register
//   in_wr_en        op writes a register
//   in_set_flags    op updates NZCV
//   wb_valid/ready  handshake with the register file
//   wb_we/rd/data   qualified write request
//   flag_n/z/c/v    architectural status flags
//   cond/cond_true  branch condition code and its evaluation
module alu_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_c,
  input  logic                  in_v,
  input  logic [2:0]            in_fun,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic                  in_set_flags,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v,
  input  logic [3:0]            cond,
  output logic                  cond_true
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]     main_data_q, main_data_d;
  logic [REG_ADDR_W-1:0] main_rd_q, main_rd_d;
  logic                  main_wr_en_q, main_wr_en_d;

  logic [DATA_W-1:0]     skid_data_q, skid_data_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic                  skid_wr_en_q, skid_wr_en_d;

  logic flag_n_q, flag_n_d;
  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;
  logic flag_v_q, flag_v_d;

  logic accept;
  logic pop;
  logic arith_op;

  // in_ready depends only on the state register and rst, so the ALU stage
  // never sees a combinational path from wb_ready.
  assign in_ready = (state_q != TWO) && !rst;
  assign wb_valid = (state_q != EMPTY);
  assign accept   = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  // The output always comes from the main entry. Writes to r0 are
  // suppressed, but the entry still pops normally.
  assign wb_we   = wb_valid && main_wr_en_q && (main_rd_q != '0);
  assign wb_rd   = main_rd_q;
  assign wb_data = main_data_q;

  // Skid-buffer control. The skid entry is only filled when main is busy and
  // not draining, and it is always promoted to main on the next pop. This
  // preserves order without ever dropping or duplicating an entry.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_rd_d    = main_rd_q;
    main_wr_en_d = main_wr_en_q;
    skid_data_d  = skid_data_q;
    skid_rd_d    = skid_rd_q;
    skid_wr_en_d = skid_wr_en_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          main_data_d  = in_result;
          main_rd_d    = in_rd;
          main_wr_en_d = in_wr_en;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d      = TWO;
          skid_data_d  = in_result;
          skid_rd_d    = in_rd;
          skid_wr_en_d = in_wr_en;
        end else if (pop && !accept) begin
          state_d = EMPTY;
        end else if (pop && accept) begin
          main_data_d  = in_result;
          main_rd_d    = in_rd;
          main_wr_en_d = in_wr_en;
        end
      end
      TWO: begin
        if (pop) begin
          state_d      = ONE;
          main_data_d  = skid_data_q;
          main_rd_d    = skid_rd_q;
          main_wr_en_d = skid_wr_en_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Flags update at the accept edge, independently of write-back stalls.
  // C and V are only meaningful for ADD/SUB, so logic and shift ops keep
  // the previous C and V values.
  assign arith_op = (in_fun == 3'b000) || (in_fun == 3'b001);

  always_comb begin
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    if (accept && in_set_flags) begin
      flag_n_d = in_result[DATA_W-1];
      flag_z_d = (in_result == '0);
      if (arith_op) begin
        flag_c_d = in_c;
        flag_v_d = in_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_rd_q    <= '0;
      main_wr_en_q <= 1'b0;
      skid_data_q  <= '0;
      skid_rd_q    <= '0;
      skid_wr_en_q <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_v_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_rd_q    <= main_rd_d;
      main_wr_en_q <= main_wr_en_d;
      skid_data_q  <= skid_data_d;
      skid_rd_q    <= skid_rd_d;
      skid_wr_en_q <= skid_wr_en_d;
      flag_n_q     <= flag_n_d;
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
      flag_v_q     <= flag_v_d;
    end
  end

  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;

  // Choose which NZCV value the condition evaluator sees. The *_d values
  // already equal the registered ones unless a flag-setting accept happens.
  logic eval_n, eval_z, eval_c, eval_v;
`ifdef ALU_WB_FLAG_BYPASS_EN
  assign eval_n = flag_n_d;
  assign eval_z = flag_z_d;
  assign eval_c = flag_c_d;
  assign eval_v = flag_v_d;
`else
  assign eval_n = flag_n_q;
  assign eval_z = flag_z_q;
  assign eval_c = flag_c_q;
  assign eval_v = flag_v_q;
`endif

  // Branch condition evaluation.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = eval_z;
      4'h1: cond_true = !eval_z;
      4'h2: cond_true = eval_c;
      4'h3: cond_true = !eval_c;
      4'h4: cond_true = eval_n;
      4'h5: cond_true = !eval_n;
      4'h6: cond_true = eval_v;
      4'h7: cond_true = !eval_v;
      4'h8: cond_true = eval_c && !eval_z;
      4'h9: cond_true = !eval_c || eval_z;
      4'hA: cond_true = (eval_n == eval_v);
      4'hB: cond_true = (eval_n != eval_v);
      4'hC: cond_true = !eval_z && (eval_n == eval_v);
      4'hD: cond_true = eval_z || (eval_n != eval_v);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
